// File: rtl/wb_store_issuer.sv
// Buffers retiring instructions with up to four memory destinations and
// serializes their stores onto the cache writeback port, one per cycle.
module wb_store_issuer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        valid_in,
  input  logic [31:0] dest1_addr,
  input  logic [31:0] dest2_addr,
  input  logic [31:0] dest3_addr,
  input  logic [31:0] dest4_addr,
  input  logic        dest1_is_mem,
  input  logic        dest2_is_mem,
  input  logic        dest3_is_mem,
  input  logic        dest4_is_mem,
  input  logic [63:0] res1,
  input  logic [63:0] res2,
  input  logic [63:0] res3,
  input  logic [63:0] res4,
  input  logic [1:0]  opsize_in,
  input  logic [6:0]  inst_ptcid_in,
  input  logic        wbaq_isfull,
  output logic [63:0] wb_memdata,
  output logic [31:0] wb_memaddr,
  output logic [1:0]  wb_size,
  output logic        wb_valid,
  output logic [6:0]  wb_ptcid,
  output logic        stall,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [PW:0]     count_q, count_d;
  logic [3:0]      mem_q   [DEPTH];
  logic [31:0]     addr_q  [DEPTH][4];
  logic [63:0]     data_q  [DEPTH][4];
  logic [1:0]      size_q  [DEPTH];
  logic [6:0]      ptcid_q [DEPTH];

  logic [31:0]     in_addr [4];
  logic [63:0]     in_data [4];
  logic [3:0]      in_mem;
  logic [1:0]      sp;
  logic            push, pop, xfer, last_slot;

  assign in_addr = '{dest1_addr, dest2_addr, dest3_addr, dest4_addr};
  assign in_data = '{res1, res2, res3, res4};
  assign in_mem  = {dest4_is_mem, dest3_is_mem, dest2_is_mem, dest1_is_mem};

  assign stall = (count_q == FULL);
  assign empty = (count_q == '0);
  assign push  = valid_in & ~stall & (|in_mem);
  assign xfer  = wb_valid;

  // Lowest-numbered slot of the head entry still waiting to be issued.
  always_comb begin
    sp = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mem_q[head_q][i]) sp = 2'(i);
    end
  end

  assign last_slot = ((mem_q[head_q] & ~(4'b0001 << sp)) == 4'b0000);
  assign pop       = xfer & last_slot;

  always_comb begin
    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int e = 0; e < DEPTH; e++) mem_q[e] <= 4'b0000;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      // The tail never aliases the head while it is being issued, so both writes are safe.
      if (xfer) mem_q[head_q][sp] <= 1'b0;
      if (push) mem_q[tail_q] <= in_mem;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int s = 0; s < 4; s++) begin
        addr_q[tail_q][s] <= in_addr[s];
        data_q[tail_q][s] <= in_data[s];
      end
      size_q[tail_q]  <= opsize_in;
      ptcid_q[tail_q] <= inst_ptcid_in;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = (count_d != '0) ? ISSUE : IDLE;
  end

  // Idle outputs read as zero, so the payload storage needs no reset.
  always_comb begin
    wb_valid   = 1'b0;
    wb_memaddr = '0;
    wb_memdata = '0;
    wb_size    = '0;
    wb_ptcid   = '0;
    if (state_q == ISSUE) begin
      wb_valid   = ~wbaq_isfull;
      wb_memaddr = addr_q[head_q][sp];
      wb_memdata = data_q[head_q][sp];
      wb_size    = size_q[head_q];
      wb_ptcid   = ptcid_q[head_q];
    end
  end

endmodule

// File: doc/wb_store_issuer.md
# wb_store_issuer

Write-side producer for the data cache's writeback address queue. Accepts retiring instructions from the writeback stage, captures every memory-destined result (up to four per instruction), and serializes them onto the cache writeback port (`wb_memdata`/`wb_memaddr`/`wb_size`/`wb_valid`/`wb_ptcid`), one store per cycle, honouring `wbaq_isfull`. Sits between the writeback stage and the memory stage's cache writeback inputs, and back-pressures writeback with `stall`.

## Interface
- `DEPTH`, 4, instruction entries buffered; power of 2, ≥2.
- `clk` input 1: single clock; all state updates on posedge.
- `clr` input 1: synchronous, active-high reset.
- `valid_in` input 1: a retiring instruction is presented this cycle.
- `dest1_addr`..`dest4_addr` input 32 each: destination addresses.
- `dest1_is_mem`..`dest4_is_mem` input 1 each: destination n is a memory store.
- `res1`..`res4` input 64 each: store data for destination n.
- `opsize_in` input 2: store size, shared by all destinations of the instruction (00=1B, 01=2B, 10=4B, 11=8B).
- `inst_ptcid_in` input 7: instruction protection-cache ID.
- `wbaq_isfull` input 1: cache writeback queue cannot accept a store this cycle.
- `wb_memdata` output 64, `wb_memaddr` output 32, `wb_size` output 2, `wb_ptcid` output 7: current store.
- `wb_valid` output 1: store offered; transferred when `wb_valid & ~wbaq_isfull`.
- `stall` output 1: buffer full; writeback must hold its instruction.
- `empty` output 1: no pending stores.

## Operation
- Circular buffer of `DEPTH` entries; each entry holds 4 slots {addr, data, mem flag}, plus size and ptcid. Pointers `log2(DEPTH)` bits, wrap modulo `DEPTH`; occupancy counter 0..`DEPTH`.
- Push: `valid_in & ~stall & (any dest_is_mem)` writes the tail entry and advances tail. An instruction with no mem destination is never enqueued (dropped, no stall impact).
- Push while `stall`=1 is ignored; upstream holds inputs.
- Issue FSM, per head entry: IDLE (empty) -> ISSUE. In ISSUE, slot pointer `sp` (2 bits) points at the lowest-numbered remaining slot with mem flag set; outputs show that slot. On transfer, clear its flag; if no flags remain, pop entry (advance head, `sp` restarts) and go to ISSUE if more entries else IDLE.
- Store order: entry order (oldest first), slot order 1->4 within an entry. Non-mem slots cost zero cycles.
- `wb_valid` = ~empty & ~wbaq_isfull (combinational gate on `wbaq_isfull`); outputs otherwise registered from buffer state.
- Simultaneous push and pop: both take effect; count unchanged. `stall` = (count == `DEPTH`), computed from registered count only (a same-cycle pop does not release stall).
- `empty` = (count == 0).

## Timing
- Reset (`clr` sampled high): count=0, head=tail=0, `sp`=0, all flags cleared, FSM IDLE. Next cycle: `wb_valid`=0, `stall`=0, `empty`=1, `wb_memdata`=0, `wb_memaddr`=0, `wb_size`=0, `wb_ptcid`=0.
- Reset mid-operation discards all pending stores; no partial entry survives.
- Latency: store pushed in cycle N is offered (`wb_valid`=1) in cycle N+1 if buffer was empty and `wbaq_isfull`=0.
- Throughput: 1 store/cycle while `wbaq_isfull`=0; entry with k mem slots drains in k transferring cycles.
- `wbaq_isfull`=1 freezes the FSM; outputs other than `wb_valid` hold steady.

## Test plan
- Reset: assert `clr` 1 cycle mid-drain of 3 pending stores -> next cycle `wb_valid`=0, `empty`=1, `stall`=0, no further stores.
- Single store: `valid_in`=1, dest2 mem, addr 0x0000_1000, data 0x1122_3344_5566_7788, opsize 10, ptcid 0x05 -> cycle N+1 `wb_valid`=1 with those values, `wb_size`=10; cycle N+2 `empty`=1.
- Slot ordering/skipping: dest1 and dest4 mem (addr 0x10, 0x40), dest2/3 not -> two consecutive transfers, 0x10 then 0x40, no idle cycle.
- Back-pressure: `wbaq_isfull`=1 for 3 cycles with pending store 0x20 -> `wb_valid`=0, `wb_memaddr` held 0x20; transfer on first cycle `wbaq_isfull`=0; store issued exactly once.
- Full/wrap: `DEPTH`=4, `wbaq_isfull`=1, push 4 single-store instructions -> `stall`=1 after 4th; 5th push ignored; release -> addresses drain in push order; push 4 more -> correct order across pointer wrap.
- Zero-mem instruction: `valid_in`=1, all `dest_is_mem`=0 -> count unchanged, `empty` stays 1, `wb_valid` stays 0.
